// File: rtl/fake_psx_pkg.sv
// -----------------------------------------------------------------------------
// fake_psx_pkg
// Shared definitions for the PlayStation controller-port host emulator:
//   - default timing parameters (in clk cycles)
//   - poll-frame TX byte constants and expected pad response bytes
//   - FSM state enumeration
//   - tx_byte(): TX byte for a given frame byte index
//   - max_int(): helper for sizing counters
// -----------------------------------------------------------------------------
package fake_psx_pkg;

   localparam int DEF_POLL_GAP    = 16;
   localparam int DEF_ATT_SETUP   = 2;
   localparam int DEF_BYTE_GAP    = 2;
   localparam int DEF_ACK_TIMEOUT = 8;

   localparam int FRAME_BYTES = 5;

   localparam logic [7:0] TX_START   = 8'h01;
   localparam logic [7:0] TX_POLL    = 8'h42;
   localparam logic [7:0] TX_IDLE    = 8'h00;
   localparam logic [7:0] ID_DIGITAL = 8'h41;
   localparam logic [7:0] READY      = 8'h5A;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      GAP,
      DONE
   } state_e;

   // Byte 0 selects the pad, byte 1 is the poll command, the rest are fillers.
   function automatic logic [7:0] tx_byte(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = TX_START;
         3'd1:    b = TX_POLL;
         default: b = TX_IDLE;
      endcase
      return b;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fake_psx_shifter.sv
// -----------------------------------------------------------------------------
// fake_psx_shifter
// 8-bit LSB-first serializer/deserializer with bit counter for one frame byte.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      load tx_byte_i and restart at bit 0 (first low phase begins)
//   sample_i     end of a high phase: shift data_i in, advance to next bit
//   tx_byte_i    byte to transmit (only read while start_i is high)
//   data_i       pad->host serial data
//   tx_bit_o     bit to drive on cmd for the low phase that begins this edge
//   last_bit_o   current bit is bit 7
//   rx_byte_o    received byte (complete after the 8th sample)
// -----------------------------------------------------------------------------
module fake_psx_shifter
   import fake_psx_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       sample_i,
   input  logic [7:0] tx_byte_i,
   input  logic       data_i,
   output logic       tx_bit_o,
   output logic       last_bit_o,
   output logic [7:0] rx_byte_o
);

   // tx_q holds the bits not yet driven; bit 0 is sent straight from tx_byte_i.
   logic [6:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic [2:0] bit_q, bit_d;

   always_comb begin
      tx_d  = tx_q;
      rx_d  = rx_q;
      bit_d = bit_q;
      if (start_i) begin
         tx_d  = tx_byte_i[7:1];
         bit_d = '0;
      end else if (sample_i) begin
         rx_d = {data_i, rx_q[7:1]};
         tx_d = {1'b1, tx_q[6:1]};
         if (bit_q != 3'd7) begin
            bit_d = bit_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q  <= '1;
         rx_q  <= '0;
         bit_q <= '0;
      end else begin
         tx_q  <= tx_d;
         rx_q  <= rx_d;
         bit_q <= bit_d;
      end
   end

   assign tx_bit_o   = start_i ? tx_byte_i[0] : tx_q[0];
   assign last_bit_o = (bit_q == 3'd7);
   assign rx_byte_o  = rx_q;

endmodule

// File: rtl/fake_psx.sv
// -----------------------------------------------------------------------------
// fake_psx
// Host-side emulator for a PlayStation digital controller port. Polls the pad
// continuously with the 5-byte frame 01 42 00 00 00 and publishes the button
// word when the pad answers with ID 0x41 / 0x5A.
// Ports:
//   clk            system clock (one cycle = one psx_clk half-period)
//   rst_n          asynchronous active-low reset
//   data_i         pad->host serial data, LSB first (used unsynchronized)
//   ack_i          pad acknowledge, active low (2-flop synchronized)
//   psx_clk_o      serial clock to pad, idle high
//   cmd_o          host->pad serial data, idle high
//   att_o          pad select, active low
//   buttons_o      last valid {byte4, byte3}, active low
//   frame_valid_o  one-cycle pulse when a valid frame completes
// Build option:
//   FAKE_PSX_ACK_CHECK_EN  when defined, each inter-byte gap waits for ack low
//                          and aborts the frame after ACK_TIMEOUT cycles.
// -----------------------------------------------------------------------------
module fake_psx
   import fake_psx_pkg::*;
#(
   parameter int POLL_GAP    = DEF_POLL_GAP,
   parameter int ATT_SETUP   = DEF_ATT_SETUP,
   parameter int BYTE_GAP    = DEF_BYTE_GAP,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        data_i,
   input  logic        ack_i,
   output logic        psx_clk_o,
   output logic        cmd_o,
   output logic        att_o,
   output logic [15:0] buttons_o,
   output logic        frame_valid_o
);

   localparam int CNT_MAX = max_int(max_int(POLL_GAP, ATT_SETUP), max_int(BYTE_GAP, ACK_TIMEOUT));
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_GAP - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(ATT_SETUP - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP - 1);
   localparam logic [2:0]       LAST_BYTE  = 3'(FRAME_BYTES - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         byte_q, byte_d;
   logic               att_q, att_d;
   logic               psx_clk_q, psx_clk_d;
   logic               cmd_q, cmd_d;
   logic               frame_valid_q, frame_valid_d;
   logic [15:0]        buttons_q, buttons_d;
   logic               id_ok_q, id_ok_d;
   logic               ready_ok_q, ready_ok_d;
   logic [7:0]         rx3_q, rx3_d;
   logic               ack_s1_q, ack_s2_q;

   logic               shift_start, shift_sample;
   logic [7:0]         tx_sel;
   logic               tx_bit, last_bit;
   logic [7:0]         rx_byte;
   logic               gap_exit, gap_abort;

   fake_psx_shifter u_shifter (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (shift_start),
      .sample_i   (shift_sample),
      .tx_byte_i  (tx_sel),
      .data_i     (data_i),
      .tx_bit_o   (tx_bit),
      .last_bit_o (last_bit),
      .rx_byte_o  (rx_byte)
   );

`ifdef FAKE_PSX_ACK_CHECK_EN
   localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

   logic ack_seen_q, ack_seen_d, ack_ok;

   // An ack pulse anywhere in the gap counts, even if it ended before BYTE_GAP.
   assign ack_ok     = ack_seen_q | ~ack_s2_q;
   assign ack_seen_d = (state_q == GAP) && ack_ok;
   assign gap_exit   = (cnt_q >= GAP_LAST) && ack_ok;
   assign gap_abort  = !gap_exit && (cnt_q == ACK_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_seen_q <= 1'b0;
      end else begin
         ack_seen_q <= ack_seen_d;
      end
   end
`else
   logic ack_sync_unused;

   assign gap_exit        = (cnt_q == GAP_LAST);
   assign gap_abort       = 1'b0;
   assign ack_sync_unused = ack_s2_q;
`endif

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         byte_q        <= '0;
         att_q         <= 1'b1;
         psx_clk_q     <= 1'b1;
         cmd_q         <= 1'b1;
         frame_valid_q <= 1'b0;
         buttons_q     <= 16'hFFFF;
         id_ok_q       <= 1'b0;
         ready_ok_q    <= 1'b0;
         rx3_q         <= '0;
         ack_s1_q      <= 1'b1;
         ack_s2_q      <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         byte_q        <= byte_d;
         att_q         <= att_d;
         psx_clk_q     <= psx_clk_d;
         cmd_q         <= cmd_d;
         frame_valid_q <= frame_valid_d;
         buttons_q     <= buttons_d;
         id_ok_q       <= id_ok_d;
         ready_ok_q    <= ready_ok_d;
         rx3_q         <= rx3_d;
         ack_s1_q      <= ack_i;
         ack_s2_q      <= ack_s1_q;
      end
   end

   // Next-state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      unique case (state_q)
         IDLE: begin
            if (cnt_q == POLL_LAST) begin
               state_d = SETUP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = SHIFT;
               cnt_d   = '0;
               byte_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SHIFT: begin
            // psx_clk high means the edge now closing is the end of a high phase
            if (psx_clk_q && last_bit) begin
               state_d = (byte_q == LAST_BYTE) ? DONE : GAP;
               cnt_d   = '0;
            end
         end
         GAP: begin
            if (gap_exit) begin
               state_d = SHIFT;
               cnt_d   = '0;
               byte_d  = byte_q + 3'd1;
            end else if (gap_abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs and datapath, keyed on the transition being taken this edge
   always_comb begin
      att_d         = (state_d == IDLE);
      psx_clk_d     = 1'b1;
      cmd_d         = 1'b1;
      shift_start   = 1'b0;
      shift_sample  = 1'b0;
      frame_valid_d = 1'b0;
      buttons_d     = buttons_q;
      id_ok_d       = id_ok_q;
      ready_ok_d    = ready_ok_q;
      rx3_d         = rx3_q;
      tx_sel        = tx_byte(byte_d);

      if (state_d == SHIFT) begin
         if (state_q != SHIFT) begin
            shift_start = 1'b1;
            psx_clk_d   = 1'b0;
            cmd_d       = tx_bit;
         end else if (!psx_clk_q) begin
            psx_clk_d = 1'b1;
            cmd_d     = cmd_q;
         end else begin
            shift_sample = 1'b1;
            psx_clk_d    = 1'b0;
            cmd_d        = tx_bit;
         end
      end else if (state_q == SHIFT) begin
         // last high phase of the byte ends: take bit 7, release cmd
         shift_sample = 1'b1;
      end

      // The byte just received is stable in the first gap cycle.
      if (state_q == GAP && cnt_q == '0) begin
         case (byte_q)
            3'd1:    id_ok_d    = (rx_byte == ID_DIGITAL);
            3'd2:    ready_ok_d = (rx_byte == READY);
            3'd3:    rx3_d      = rx_byte;
            default: ;
         endcase
      end

      if (state_q == DONE && id_ok_q && ready_ok_q) begin
         frame_valid_d = 1'b1;
         buttons_d     = {rx_byte, rx3_q};
      end
   end

   assign psx_clk_o     = psx_clk_q;
   assign cmd_o         = cmd_q;
   assign att_o         = att_q;
   assign buttons_o     = buttons_q;
   assign frame_valid_o = frame_valid_q;

endmodule

// File: tb/tb_fake_psx.sv
// -----------------------------------------------------------------------------
// tb_fake_psx
// Pad model answers each poll frame with a configurable 5-byte response and
// collects the cmd bytes. Expected cmd bytes and expected frame results are
// queued by the stimulus thread; the pad model and a frame monitor pop and
// compare as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_fake_psx;

   localparam int POLL_GAP    = 16;
   localparam int ATT_SETUP   = 2;
   localparam int ACK_TIMEOUT = 8;

   typedef struct {
      logic        valid;
      logic [15:0] buttons;
      int          pulses;
   } frame_exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        data = 1'b1;
   logic        ack = 1'b1;
   logic        psx_clk, cmd, att, frame_valid;
   logic [15:0] buttons;

   int          n_checks = 0;
   int          n_fail = 0;

   logic [7:0]  pad_bytes [5];
   logic [7:0]  tx_exp [5];
   logic        ack_en = 1'b1;
   logic [7:0]  exp_cmd_q [$];
   frame_exp_t  exp_frame_q [$];

   int          bitn = 0;
   int          ack_dly = 0;
   logic [7:0]  cmd_acc = 8'h00;
   int          pulses = 0;
   int          fv_cnt = 0;
   int          frame_no = 0;
   logic        att_prev = 1'b1;

   fake_psx dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_i        (data),
      .ack_i         (ack),
      .psx_clk_o     (psx_clk),
      .cmd_o         (cmd),
      .att_o         (att),
      .buttons_o     (buttons),
      .frame_valid_o (frame_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Pad model: drives data during each low phase, records cmd, pulses ack
   always @(negedge clk) begin
      if (!rst_n || att) begin
         bitn    = 0;
         data    = 1'b1;
         ack     = 1'b1;
         ack_dly = 0;
      end else begin
         if (ack_dly > 0) begin
            ack_dly--;
            ack = !(ack_dly == 0 && ack_en);
         end else begin
            ack = 1'b1;
         end
         if (!psx_clk) begin
            int byte_i;
            int bit_i;
            byte_i = bitn / 8;
            bit_i  = bitn % 8;
            if (byte_i < 5) begin
               data           = pad_bytes[byte_i][bit_i];
               cmd_acc[bit_i] = cmd;
            end
            if (bit_i == 7) begin
               if (exp_cmd_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL cmd_byte: got 0x%0h, expected none", cmd_acc);
               end else begin
                  check($sformatf("cmd_byte%0d", byte_i), {24'h0, cmd_acc}, {24'h0, exp_cmd_q.pop_front()});
               end
               if (byte_i < 4) ack_dly = 2;
            end
            bitn++;
         end
      end
   end

   // Frame monitor: a frame ends when att rises (outside reset)
   always @(negedge clk) begin
      if (!rst_n) begin
         pulses   = 0;
         fv_cnt   = 0;
         att_prev = 1'b1;
      end else begin
         if (!att && !psx_clk) pulses++;
         if (frame_valid) fv_cnt++;
         if (att && !att_prev) begin
            frame_no++;
            $display("frame %0d: frame_valid pulses=%0d buttons=%h psx_clk pulses=%0d",
                     frame_no, fv_cnt, buttons, pulses);
            if (exp_frame_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL frame_end: got frame %0d, expected none", frame_no);
            end else begin
               frame_exp_t e;
               e = exp_frame_q.pop_front();
               check("frame_valid_count", fv_cnt, {31'h0, e.valid});
               check("buttons", {16'h0, buttons}, {16'h0, e.buttons});
               check("psx_clk_pulses", pulses, e.pulses);
            end
            pulses = 0;
            fv_cnt = 0;
         end
         att_prev = att;
      end
   end

   task automatic push_frame(input logic v, input logic [15:0] btn, input int p, input int nbytes);
      frame_exp_t e;
      e.valid   = v;
      e.buttons = btn;
      e.pulses  = p;
      exp_frame_q.push_back(e);
      for (int i = 0; i < nbytes; i++) exp_cmd_q.push_back(tx_exp[i]);
   endtask

   task automatic wait_frames();
      int cyc;
      cyc = 0;
      while (exp_frame_q.size() != 0 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (exp_frame_q.size() != 0) begin
         n_fail++;
         $display("FAIL frame_timeout: got %0d frames pending, expected 0", exp_frame_q.size());
         exp_frame_q.delete();
         exp_cmd_q.delete();
      end
   endtask

   task automatic run_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4, input logic v, input logic [15:0] btn);
      pad_bytes[0] = 8'hFF;
      pad_bytes[1] = b1;
      pad_bytes[2] = b2;
      pad_bytes[3] = b3;
      pad_bytes[4] = b4;
      push_frame(v, btn, 40, 5);
      wait_frames();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tx_exp[0] = 8'h01;
      tx_exp[1] = 8'h42;
      tx_exp[2] = 8'h00;
      tx_exp[3] = 8'h00;
      tx_exp[4] = 8'h00;
      for (int i = 0; i < 5; i++) pad_bytes[i] = 8'hFF;

      // Reset state
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_psx_clk", {31'h0, psx_clk}, 1);
      check("rst_cmd", {31'h0, cmd}, 1);
      check("rst_att", {31'h0, att}, 1);
      check("rst_frame_valid", {31'h0, frame_valid}, 0);
      check("rst_buttons", {16'h0, buttons}, 32'hFFFF);

      // First frame, data tied high: ID 0xFF, no pulse
      push_frame(1'b0, 16'hFFFF, 40, 5);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i < POLL_GAP; i++) begin
         @(posedge clk);
         #1;
         check("idle_att", {31'h0, att}, 1);
      end
      check("idle_psx_clk", {31'h0, psx_clk}, 1);
      check("idle_cmd", {31'h0, cmd}, 1);
      @(posedge clk);
      #1;
      check("att_fall", {31'h0, att}, 0);
      check("setup_psx_clk", {31'h0, psx_clk}, 1);
      wait_frames();

      // Valid and invalid pad responses
      run_frame(8'h41, 8'h5A, 8'hFE, 8'hFF, 1'b1, 16'hFFFE);
      run_frame(8'h41, 8'h5A, 8'h5A, 8'hA5, 1'b1, 16'hA55A);
      run_frame(8'h73, 8'h5A, 8'h00, 8'h00, 1'b0, 16'hA55A);
      run_frame(8'h41, 8'h5B, 8'h00, 8'h00, 1'b0, 16'hA55A);
      run_frame(8'h41, 8'h5A, 8'h00, 8'h00, 1'b1, 16'h0000);

      // Reset during byte 2
      pad_bytes[1] = 8'h41;
      pad_bytes[2] = 8'h5A;
      pad_bytes[3] = 8'h12;
      pad_bytes[4] = 8'h34;
      push_frame(1'b1, 16'h3412, 40, 5);
      begin
         int cyc;
         cyc = 0;
         while (bitn < 20 && cyc < 400) begin
            @(negedge clk);
            cyc++;
         end
         n_checks++;
         if (bitn < 20) begin
            n_fail++;
            $display("FAIL byte2_timeout: got bit %0d, expected 20", bitn);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      check("midrst_psx_clk", {31'h0, psx_clk}, 1);
      check("midrst_cmd", {31'h0, cmd}, 1);
      check("midrst_att", {31'h0, att}, 1);
      check("midrst_frame_valid", {31'h0, frame_valid}, 0);
      check("midrst_buttons", {16'h0, buttons}, 32'hFFFF);
      exp_cmd_q.delete();
      exp_frame_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_frame(8'h41, 8'h5A, 8'h12, 8'h34, 1'b1, 16'h3412);

`ifdef FAKE_PSX_ACK_CHECK_EN
      // No ack: abort after byte 0
      ack_en = 1'b0;
      push_frame(1'b0, 16'h3412, 8, 1);
      begin
         int cyc;
         int span;
         cyc = 0;
         while (att && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         span = 0;
         while (!att && span < 100) begin
            @(posedge clk);
            #1;
            span++;
         end
         check("abort_att_span", span, ATT_SETUP + 16 + ACK_TIMEOUT);
      end
      wait_frames();
      ack_en = 1'b1;
      run_frame(8'h41, 8'h5A, 8'hFE, 8'hFF, 1'b1, 16'hFFFE);
`else
      // ack never asserted: frames still complete
      ack_en = 1'b0;
      run_frame(8'h41, 8'h5A, 8'hFE, 8'hFF, 1'b1, 16'hFFFE);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
